// File: rtl/cpu_ctrl_pkg.sv
// Shared state encoding and default sizes for the CPU run controller.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RESET = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    STEP  = 3'd5
  } run_state_t;

  localparam int DEF_CYCLES_PER_INSTR = 7;
  localparam int DEF_PC_W             = 11;
  localparam int SW_PC_W              = 10;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-facing bundle for cpu_run_ctrl: keys and switches in, CPU control and status out.
interface cpu_run_ctrl_if #(
  parameter int PC_W = cpu_ctrl_pkg::DEF_PC_W
);
  import cpu_ctrl_pkg::*;

  logic               key_start_n;
  logic               key_step_n;
  logic               sw_run_mode;
  logic [SW_PC_W-1:0] sw_start_pc;
  logic [PC_W-1:0]    start_pc;
  logic               cpu_rst_n;
  logic               cpu_en;
  logic [15:0]        instr_count;
  logic [2:0]         state_dbg;

  modport master (
    output key_start_n, key_step_n, sw_run_mode, sw_start_pc,
    input  start_pc, cpu_rst_n, cpu_en, instr_count, state_dbg
  );

  modport slave (
    input  key_start_n, key_step_n, sw_run_mode, sw_start_pc,
    output start_pc, cpu_rst_n, cpu_en, instr_count, state_dbg
  );

endinterface

// File: rtl/cpu_run_ctrl_key_debounce.sv
// Two-flop synchronizer plus debounce counter for one active-low key; pulses once per accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_keyN,
  output logic o_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // The level flips on the N-th consecutive cycle of disagreement; any agreeing cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_keyN;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller upstream of integrated_cpu: reset/load sequencing, free-run or single-step gating.
// Single stepping (PAUSE/STEP, step key, run-mode switch) exists only when CPU_SINGLE_STEP_EN is defined.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int CYCLES_PER_INSTR = DEF_CYCLES_PER_INSTR,
  parameter int RST_CYCLES       = 2,
  parameter int LOAD_CYCLES      = 1,
  parameter int PC_W             = DEF_PC_W
) (
  input logic           clk,
  input logic           rst,
  cpu_run_ctrl_if.slave io_bus
);

  localparam int PH_W    = (CYCLES_PER_INSTR > 1) ? $clog2(CYCLES_PER_INSTR) : 1;
  localparam int SEQ_MAX = (RST_CYCLES > LOAD_CYCLES) ? RST_CYCLES : LOAD_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CYCLES_PER_INSTR - 1);
  localparam logic [SEQ_W-1:0] RST_LAST  = SEQ_W'(RST_CYCLES - 1);
  localparam logic [SEQ_W-1:0] LOAD_LAST = SEQ_W'(LOAD_CYCLES - 1);

  logic w_startPress;
  logic w_stepPress;
  logic w_runMode;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_startKey (
    .clk     (clk),
    .rst     (rst),
    .i_keyN  (io_bus.key_start_n),
    .o_press (w_startPress)
  );

`ifdef CPU_SINGLE_STEP_EN
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stepKey (
    .clk     (clk),
    .rst     (rst),
    .i_keyN  (io_bus.key_step_n),
    .o_press (w_stepPress)
  );
  assign w_runMode = io_bus.sw_run_mode;
`else
  // Without stepping the controller behaves as if free-run were always selected.
  logic w_unused;
  assign w_unused    = &{1'b0, io_bus.key_step_n, io_bus.sw_run_mode};
  assign w_stepPress = 1'b0;
  assign w_runMode   = 1'b1;
`endif

  run_state_t       r_state,  w_nextState;
  logic [PH_W-1:0]  r_phase,  w_nextPhase;
  logic [SEQ_W-1:0] r_seqCnt, w_nextSeq;
  logic [15:0]      r_instrCount, w_nextCount;
  logic [PC_W-1:0]  r_startPc,    w_nextPc;
  logic             r_cpuRstN;
  logic             r_cpuEn;

  always_comb begin
    w_nextState = r_state;
    w_nextPhase = r_phase;
    w_nextSeq   = r_seqCnt;
    w_nextCount = r_instrCount;
    w_nextPc    = r_startPc;
    if (w_startPress) begin
      w_nextState = RESET;
      w_nextPhase = '0;
      w_nextSeq   = '0;
      w_nextCount = '0;
      w_nextPc    = PC_W'(io_bus.sw_start_pc);
    end else begin
      case (r_state)
        IDLE: w_nextState = IDLE;
        RESET: begin
          if (r_seqCnt == RST_LAST) begin
            w_nextState = LOAD;
            w_nextSeq   = '0;
          end else begin
            w_nextSeq = r_seqCnt + SEQ_W'(1);
          end
        end
        LOAD: begin
          if (r_seqCnt == LOAD_LAST) begin
            w_nextState = w_runMode ? RUN : PAUSE;
            w_nextSeq   = '0;
          end else begin
            w_nextSeq = r_seqCnt + SEQ_W'(1);
          end
        end
        // Mode is only sampled at the last phase so an instruction is never cut short.
        RUN: begin
          if (r_phase == PH_LAST) begin
            w_nextPhase = '0;
            w_nextCount = r_instrCount + 16'd1;
            if (!w_runMode) w_nextState = PAUSE;
          end else begin
            w_nextPhase = r_phase + PH_W'(1);
          end
        end
        PAUSE: begin
          w_nextPhase = '0;
          if (w_stepPress)    w_nextState = STEP;
          else if (w_runMode) w_nextState = RUN;
        end
        STEP: begin
          if (r_phase == PH_LAST) begin
            w_nextPhase = '0;
            w_nextCount = r_instrCount + 16'd1;
            w_nextState = PAUSE;
          end else begin
            w_nextPhase = r_phase + PH_W'(1);
          end
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // CPU controls are registered from the next state so they line up with state_dbg.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_phase      <= '0;
      r_seqCnt     <= '0;
      r_instrCount <= '0;
      r_startPc    <= '0;
      r_cpuRstN    <= 1'b0;
      r_cpuEn      <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_phase      <= w_nextPhase;
      r_seqCnt     <= w_nextSeq;
      r_instrCount <= w_nextCount;
      r_startPc    <= w_nextPc;
      r_cpuRstN    <= !((w_nextState == IDLE) || (w_nextState == RESET));
      r_cpuEn      <= (w_nextState == LOAD) || (w_nextState == RUN) || (w_nextState == STEP);
    end
  end

  assign io_bus.start_pc    = r_startPc;
  assign io_bus.cpu_rst_n   = r_cpuRstN;
  assign io_bus.cpu_en      = r_cpuEn;
  assign io_bus.instr_count = r_instrCount;
  assign io_bus.state_dbg   = r_state;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus a randomized run against a cycle model.
module tb_cpu_run_ctrl;

  localparam int DEB   = 4;
  localparam int CPI   = 7;
  localparam int RSTC  = 2;
  localparam int LOADC = 1;
`ifdef CPU_SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  localparam int S_IDLE = 0, S_RESET = 1, S_LOAD = 2, S_RUN = 3, S_PAUSE = 4, S_STEP = 5;

  logic clk = 1'b0;
  logic rst;

  cpu_run_ctrl_if #(.PC_W(11)) bus ();

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES  (DEB),
    .CYCLES_PER_INSTR (CPI),
    .RST_CYCLES       (RSTC),
    .LOAD_CYCLES      (LOADC),
    .PC_W             (11)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: state number, cycles left in the current timed segment, retired count, latched PC.
  int mState, mLeft, mCount, mPc;
  int hist1[2], hist2[2], lvl[2], runLen[2];
  bit pend[2];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    mState = S_IDLE; mLeft = 0; mCount = 0; mPc = 0;
    for (int k = 0; k < 2; k++) begin
      hist1[k] = 1; hist2[k] = 1; lvl[k] = 1; runLen[k] = 0; pend[k] = 1'b0;
    end
  endtask

  task automatic modelStep();
    int raw[2];
    int delayed;
    bit startEv, stepEv;
    if (rst) begin
      modelReset();
      return;
    end
    raw[0]  = int'(bus.key_start_n);
    raw[1]  = int'(bus.key_step_n);
    startEv = pend[0];
    stepEv  = pend[1] && STEP_EN;
    if (startEv) begin
      mPc = int'(bus.sw_start_pc); mCount = 0; mState = S_RESET; mLeft = RSTC;
    end else begin
      case (mState)
        S_RESET: begin
          mLeft--;
          if (mLeft == 0) begin mState = S_LOAD; mLeft = LOADC; end
        end
        S_LOAD: begin
          mLeft--;
          if (mLeft == 0) begin
            mState = (STEP_EN && !bus.sw_run_mode) ? S_PAUSE : S_RUN;
            mLeft  = CPI;
          end
        end
        S_RUN: begin
          mLeft--;
          if (mLeft == 0) begin
            mCount = (mCount + 1) % 65536;
            mLeft  = CPI;
            if (STEP_EN && !bus.sw_run_mode) mState = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (stepEv) begin mState = S_STEP; mLeft = CPI; end
          else if (!STEP_EN || bus.sw_run_mode) begin mState = S_RUN; mLeft = CPI; end
        end
        S_STEP: begin
          mLeft--;
          if (mLeft == 0) begin mCount = (mCount + 1) % 65536; mState = S_PAUSE; end
        end
        default: ;
      endcase
    end
    for (int k = 0; k < 2; k++) begin
      delayed  = hist2[k];
      hist2[k] = hist1[k];
      hist1[k] = raw[k];
      pend[k]  = 1'b0;
      if (delayed != lvl[k]) begin
        runLen[k]++;
        if (runLen[k] == DEB) begin
          lvl[k] = delayed; runLen[k] = 0; pend[k] = (delayed == 0);
        end
      end else begin
        runLen[k] = 0;
      end
    end
  endtask

  task automatic compareAll();
    int expEn, expRstN;
    expEn   = (mState == S_LOAD || mState == S_RUN || mState == S_STEP) ? 1 : 0;
    expRstN = (mState == S_IDLE || mState == S_RESET) ? 0 : 1;
    checkOutput("state", int'(bus.state_dbg), mState);
    checkOutput("cpuEn", int'(bus.cpu_en), expEn);
    checkOutput("cpuRstN", int'(bus.cpu_rst_n), expRstN);
    checkOutput("instrCount", int'(bus.instr_count), mCount);
    checkOutput("startPc", int'(bus.start_pc), mPc);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyStimulus(input bit r, input bit startN, input bit stepN,
                               input bit mode, input logic [9:0] pc);
    rst             = r;
    bus.key_start_n = startN;
    bus.key_step_n  = stepN;
    bus.sw_run_mode = mode;
    bus.sw_start_pc = pc;
    tick();
  endtask

  // Hold a key low long enough to be accepted; the event is acted on at the 7th edge.
  task automatic pressKey(input bit isStep);
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b0, isStep, !isStep, bus.sw_run_mode, bus.sw_start_pc);
    applyStimulus(1'b0, 1'b1, 1'b1, bus.sw_run_mode, bus.sw_start_pc);
  endtask

  initial begin
    int found, enTotal, countBefore;
    int startHold, stepHold;
    bit sN, pN, mode, rstV;
    logic [9:0] pc;

    rst = 1'b1;
    bus.key_start_n = 1'b1; bus.key_step_n = 1'b1;
    bus.sw_run_mode = 1'b1; bus.sw_start_pc = 10'h000;
    modelReset();

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'h000);
    checkOutput("rstState", int'(bus.state_dbg), S_IDLE);
    checkOutput("rstEn", int'(bus.cpu_en), 0);
    checkOutput("rstRstN", int'(bus.cpu_rst_n), 0);
    checkOutput("rstCount", int'(bus.instr_count), 0);
    checkOutput("rstPc", int'(bus.start_pc), 0);

    // Start key edge: state stays IDLE for 6 edges, RESET at edges 7-8, LOAD at 9.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'h000);
    checkOutput("preEventState", int'(bus.state_dbg), S_IDLE);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'h000);
    checkOutput("edge7State", int'(bus.state_dbg), S_RESET);
    checkOutput("edge7RstN", int'(bus.cpu_rst_n), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'h000);
    checkOutput("edge8State", int'(bus.state_dbg), S_RESET);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'h000);
    checkOutput("edge9State", int'(bus.state_dbg), S_LOAD);
    checkOutput("edge9En", int'(bus.cpu_en), 1);

    // Short glitches on the start key must never be accepted.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'h000);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'h000);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'h000);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'h000);
    checkOutput("glitchIdle", int'(bus.state_dbg), S_IDLE);

    // Free run: 10 instructions retired 71 cycles after the enable rises.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10'h012);
    pressKey(1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.cpu_en) found = 1;
    end
    checkOutput("enRiseSeen", found, 1);
    enTotal = 0;
    for (int i = 0; i < 71; i++) begin
      tick();
      enTotal += int'(bus.cpu_en);
    end
    checkOutput("runEnHigh", enTotal, 71);
    checkOutput("runCount10", int'(bus.instr_count), 10);
    checkOutput("runPc", int'(bus.start_pc), 'h012);

    // Restart while running clears the count and replays the reset pulse.
    pressKey(1'b0);
    checkOutput("restartState", int'(bus.state_dbg), S_RESET);
    checkOutput("restartCount", int'(bus.instr_count), 0);
    tick();
    checkOutput("restartHold", int'(bus.cpu_rst_n), 0);
    tick();
    checkOutput("restartLoad", int'(bus.state_dbg), S_LOAD);

`ifdef CPU_SINGLE_STEP_EN
    bus.sw_run_mode = 1'b0;
    pressKey(1'b0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (int'(bus.state_dbg) == S_PAUSE) found = 1;
    end
    checkOutput("pauseSeen", found, 1);
    checkOutput("pauseEn", int'(bus.cpu_en), 0);
    pressKey(1'b1);
    checkOutput("stepEntered", int'(bus.state_dbg), S_STEP);
    enTotal = int'(bus.cpu_en);
    for (int i = 0; i < 10; i++) begin
      tick();
      enTotal += int'(bus.cpu_en);
    end
    checkOutput("stepEnCycles", enTotal, 7);
    checkOutput("stepCount", int'(bus.instr_count), 1);

    bus.sw_run_mode = 1'b1;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      tick();
      if (int'(bus.state_dbg) == S_RUN) found = 1;
    end
    checkOutput("resumeRun", found, 1);
    for (int i = 0; i < 3; i++) tick();
    bus.sw_run_mode = 1'b0;
    countBefore = int'(bus.instr_count);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (int'(bus.state_dbg) == S_PAUSE) found = 1;
    end
    checkOutput("dropToPause", found, 1);
    checkOutput("dropCount", int'(bus.instr_count), (countBefore + 1) % 65536);

    pressKey(1'b1);
    tick(); tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, bus.sw_start_pc);
    checkOutput("rstInStepState", int'(bus.state_dbg), S_IDLE);
    checkOutput("rstInStepEn", int'(bus.cpu_en), 0);
`endif

    // Randomized run: every cycle compared against the model.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'h000);
    sN = 1'b1; pN = 1'b1; mode = 1'b1; pc = 10'h000;
    startHold = 3; stepHold = 5;
    for (int i = 0; i < 3000; i++) begin
      if (startHold <= 0) begin
        sN = ~sN;
        startHold = sN ? int'($urandom_range(40, 400)) : int'($urandom_range(1, 8));
      end
      if (stepHold <= 0) begin
        pN = ~pN;
        stepHold = pN ? int'($urandom_range(1, 20)) : int'($urandom_range(2, 9));
      end
      if ($urandom_range(0, 59) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) pc = 10'($urandom_range(0, 1023));
      rstV = ($urandom_range(0, 799) == 0);
      applyStimulus(rstV, sN, pN, mode, pc);
      startHold--;
      stepHold--;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Board-facing run controller that sits directly upstream of `integrated_cpu`, between the DE1 push-buttons/switches and the CPU core. It debounces the start and step keys and latches the start PC from the switches. It sequences the CPU through reset and the start-PC load cycle, then gates the CPU with a clock enable, either free-running or one instruction (`CYCLES_PER_INSTR` clocks) per step press. It also keeps a retired-instruction counter for the HEX display logic downstream.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a key level (10 ms at 50 MHz).
- `CYCLES_PER_INSTR`, default 7: CPU clocks per instruction.
- `RST_CYCLES`, default 2: cycles `cpu_rst_n` is held low.
- `LOAD_CYCLES`, default 1: extra enabled cycles for the CPU to load `start_pc`.
- `PC_W`, default 11: start PC width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: `CLOCK_50` domain clock.
- `rst` in 1: synchronous, active-high reset.
- `key_start_n` in 1: raw start key, active low, asynchronous.
- `key_step_n` in 1: raw step key, active low, asynchronous.
- `sw_run_mode` in 1: 1 = free run, 0 = single step.
- `sw_start_pc` in 10: start address switches.
- `start_pc` out PC_W: latched start PC, zero-extended.
- `cpu_rst_n` out 1: CPU reset, active low.
- `cpu_en` out 1: CPU clock enable.
- `instr_count` out 16: instructions retired since last start.
- `state_dbg` out 3: current FSM state encoding, for LEDR.

## Operation
- **Key path:** each key goes through a 2-FF synchronizer and then a debounce counter.
  - The debounced level changes only after the synchronized raw level differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A press event is a one-cycle pulse on a debounced 1→0 transition. Release generates nothing.
- **FSM states:** IDLE=0, RESET=1, LOAD=2, RUN=3, PAUSE=4, STEP=5.
  - **IDLE:** `cpu_rst_n`=0, `cpu_en`=0. A start event goes to RESET.
  - **Start event in any state:** latch `sw_start_pc` into `start_pc`, clear `instr_count`, clear the phase counter, go to RESET. This takes priority over a simultaneous step event.
  - **RESET:** `cpu_rst_n`=0 and `cpu_en`=0 for exactly `RST_CYCLES` cycles, then go to LOAD.
  - **LOAD:** `cpu_rst_n`=1 and `cpu_en`=1 for `LOAD_CYCLES` cycles, then go to RUN if `sw_run_mode`=1, else PAUSE. LOAD cycles do not count toward `instr_count`.
  - **RUN:** `cpu_en`=1. The phase counter runs 0..`CYCLES_PER_INSTR`-1. When it wraps to 0, `instr_count` increments.
    - If `sw_run_mode` is 0 when the phase is at its last value, go to PAUSE after that cycle, so an instruction is never split.
  - **PAUSE:** `cpu_en`=0, phase=0. A step event goes to STEP. `sw_run_mode`=1 goes to RUN.
  - **STEP:** `cpu_en`=1 for exactly `CYCLES_PER_INSTR` cycles, then `instr_count` increments and the FSM goes to PAUSE. Step events during STEP are dropped. Mode changes during STEP are ignored until PAUSE.
- **`instr_count`:** wraps 0xFFFF→0x0000.
- **Phase counter width:** `$clog2(CYCLES_PER_INSTR)`.

## Timing
- All outputs are registered.
- **Reset values:** `start_pc`=0, `cpu_rst_n`=0, `cpu_en`=0, `instr_count`=0, `state_dbg`=IDLE. Debounced key levels reset to 1 (released); synchronizers reset to 1.
- **Start latency:**
  - Raw key edge to press event: 2 + `DEBOUNCE_CYCLES` cycles.
  - Press event to `cpu_rst_n` low: 1 cycle.
- **After a start event:** `cpu_rst_n` is low for cycles 1..`RST_CYCLES`. `cpu_en` rises in the cycle after that.
- **`instr_count` update:** visible the cycle after the last enabled cycle of an instruction.
- **`rst` asserted in any state:** all outputs return to reset values on the next edge, including during RESET or STEP.

## Configuration
- **`CPU_SINGLE_STEP_EN` defined:** behaviour as above.
- **`CPU_SINGLE_STEP_EN` undefined:**
  - PAUSE and STEP are not generated and the step debouncer is not instantiated.
  - `key_step_n` and `sw_run_mode` are ignored.
  - LOAD always goes to RUN, and RUN never leaves except on a start event or `rst`.

## Structure
- **Package `cpu_ctrl_pkg`:** holds the state enum `run_state_t` and the default parameter constants (`CYCLES_PER_INSTR`=7, `PC_W`=11).
- **Sub-module `key_debounce`:** synchronizer, debounce counter and press-pulse generator, with parameter `DEBOUNCE_CYCLES`. It is instantiated once per key.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4.
1. Assert `rst`, then hold `key_start_n`=0 for 6 cycles → `cpu_rst_n` goes low 7 cycles after the key edge and stays low exactly 2 cycles. All outputs are at reset values before the event.
2. Pulse `key_start_n` low for 3 cycles, repeated with gaps of 2 cycles → no press event, state stays IDLE.
3. `sw_run_mode`=1, `sw_start_pc`=0x012, then start → `start_pc`=0x012. `cpu_en` is high continuously after RESET. 71 cycles after `cpu_en` rises, `instr_count`=10.
4. `sw_run_mode`=0, then start and one step press → `cpu_en` is high 1 cycle (LOAD), low in PAUSE, then high exactly 7 cycles after the step event. `instr_count` goes 0→1. A second step press during STEP is ignored.
5. In RUN, drop `sw_run_mode` at phase 3 → `cpu_en` stays high through phase 6, then goes low with state PAUSE and `instr_count` incremented once.
6. Start press in RUN with `instr_count`=5 → `instr_count`=0 and a new 2-cycle reset pulse. Separately, assert `rst` during STEP → IDLE with `cpu_en`=0 on the next edge.
